// File: rtl/mem_request_initiator.sv
// rtl/mem_request_initiator.sv - fetch/LSU arbiter driving the helper-memory request/complete port.
// Optional wait-state abort: define MEM_REQ_TIMEOUT_EN (adds timeout_o and TIMEOUT_CYCLES).
module mem_request_initiator #(
  parameter int ADDRES_BIT = 32,
  parameter int DATA_BIT   = 32
`ifdef MEM_REQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fetch_req_i,
  input  logic [ADDRES_BIT-1:0] fetch_addr_i,
  output logic [DATA_BIT-1:0]   fetch_data_o,
  output logic                  fetch_done_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [ADDRES_BIT-1:0] lsu_addr_i,
  input  logic [DATA_BIT-1:0]   lsu_wdata_i,
  output logic [DATA_BIT-1:0]   lsu_rdata_o,
  output logic                  lsu_done_o,
  output logic                  lsu_misaligned_o,
  output logic [ADDRES_BIT-1:0] mem_addr_o,
  output logic [DATA_BIT-1:0]   mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_get_instruction_o,
  output logic                  mem_get_data_o,
  input  logic [DATA_BIT-1:0]   mem_rdata_i,
  input  logic                  mem_instruction_completed_i,
  input  logic                  mem_data_completed_i
`ifdef MEM_REQ_TIMEOUT_EN
  ,
  output logic                  timeout_o
`endif
);

  typedef enum logic [2:0] {IDLE, INSTR_WAIT, DATA_WAIT, WRITE, RESP} state_t;

  state_t                state, state_nxt;
  logic [ADDRES_BIT-1:0] addr_q;
  logic [DATA_BIT-1:0]   wdata_q;
  logic [DATA_BIT-1:0]   fetch_data_q;
  logic [DATA_BIT-1:0]   lsu_rdata_q;
  logic                  client_lsu_q;
  logic                  misaligned_q;
  logic                  lsu_misaligned_req;
  logic                  timed_out;

  assign lsu_misaligned_req = lsu_req_i && (lsu_addr_i[1:0] != 2'b00);

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Cleared in IDLE so every wait state starts counting from zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt  <= '0;
          timeout_q <= 1'b0;
        end
        INSTR_WAIT, DATA_WAIT: begin
          if (timed_out) begin
            timeout_q <= 1'b1;
          end else if (!((state == INSTR_WAIT) ? mem_instruction_completed_i
                                                : mem_data_completed_i)) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (lsu_req_i) begin
          if (lsu_misaligned_req) state_nxt = RESP;
          else if (lsu_we_i)      state_nxt = WRITE;
          else                    state_nxt = DATA_WAIT;
        end else if (fetch_req_i) begin
          state_nxt = INSTR_WAIT;
        end
      end
      INSTR_WAIT: if (timed_out || mem_instruction_completed_i) state_nxt = RESP;
      DATA_WAIT:  if (timed_out || mem_data_completed_i)        state_nxt = RESP;
      WRITE:      state_nxt = RESP;
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o            = '0;
    mem_wdata_o           = '0;
    mem_we_o              = 1'b0;
    mem_get_instruction_o = 1'b0;
    mem_get_data_o        = 1'b0;
    fetch_done_o          = 1'b0;
    lsu_done_o            = 1'b0;
    lsu_misaligned_o      = 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
    timeout_o             = 1'b0;
`endif
    case (state)
      INSTR_WAIT: begin
        mem_addr_o            = addr_q;
        mem_get_instruction_o = !timed_out;
      end
      DATA_WAIT: begin
        mem_addr_o     = addr_q;
        mem_get_data_o = !timed_out;
      end
      WRITE: begin
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_we_o    = 1'b1;
      end
      RESP: begin
        fetch_done_o     = !client_lsu_q;
        lsu_done_o       = client_lsu_q;
        lsu_misaligned_o = client_lsu_q && misaligned_q;
`ifdef MEM_REQ_TIMEOUT_EN
        timeout_o        = timeout_q;
`endif
      end
      default: ;
    endcase
  end

  // Request fields are latched only in IDLE, so clients may change inputs mid-transaction.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      client_lsu_q <= 1'b0;
      misaligned_q <= 1'b0;
      fetch_data_q <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_req_i) begin
            addr_q       <= lsu_addr_i;
            wdata_q      <= lsu_wdata_i;
            client_lsu_q <= 1'b1;
            misaligned_q <= lsu_misaligned_req;
            if (lsu_misaligned_req) lsu_rdata_q <= '0;
          end else if (fetch_req_i) begin
            addr_q       <= fetch_addr_i;
            wdata_q      <= '0;
            client_lsu_q <= 1'b0;
            misaligned_q <= 1'b0;
          end
        end
        INSTR_WAIT: begin
          if (timed_out)                        fetch_data_q <= '0;
          else if (mem_instruction_completed_i) fetch_data_q <= mem_rdata_i;
        end
        DATA_WAIT: begin
          if (timed_out)                 lsu_rdata_q <= '0;
          else if (mem_data_completed_i) lsu_rdata_q <= mem_rdata_i;
        end
        default: ;
      endcase
    end
  end

  assign fetch_data_o = fetch_data_q;
  assign lsu_rdata_o  = lsu_rdata_q;

endmodule
